// File: rtl/ex_mem_skid_pkg.sv
// Shared constants and types for the EX->MEM skid stage.
// Occupancy encodings double as the FSM state values.
package ex_mem_skid_pkg;

  localparam int REG_LEN_DEF      = 32;
  localparam int REG_ADDR_LEN_DEF = 5;
  localparam int CTRL_W_DEF       = 4;
  localparam int CNT_W_DEF        = 16;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // Packed entry layout, MSB first: {rd_data, rd_addr, rd_enable, ctrl}
  function automatic int entry_width(input int reg_len, input int addr_len, input int ctrl_w);
    return reg_len + addr_len + 1 + ctrl_w;
  endfunction

endpackage

// File: rtl/ex_mem_skid_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;
  logic             at_max;

  assign at_max = (count_reg == {WIDTH{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (inc && !at_max) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/ex_mem_skid.sv
// EX->MEM pipeline stage with a two-entry (main + skid) valid/ready buffer,
// synchronous flush and a saturating back-pressure cycle counter.
module ex_mem_skid
  import ex_mem_skid_pkg::*;
#(
  parameter int REG_LEN      = REG_LEN_DEF,
  parameter int REG_ADDR_LEN = REG_ADDR_LEN_DEF,
  parameter int CTRL_W       = CTRL_W_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    ex_valid,
  output logic                    ex_ready,
  input  logic [REG_LEN-1:0]      ex_rd_data,
  input  logic [REG_ADDR_LEN-1:0] ex_rd_addr,
  input  logic                    ex_rd_enable,
  input  logic [CTRL_W-1:0]       ex_ctrl,
  output logic                    mem_valid,
  input  logic                    mem_ready,
  output logic [REG_LEN-1:0]      mem_rd_data,
  output logic [REG_ADDR_LEN-1:0] mem_rd_addr,
  output logic                    mem_rd_enable,
  output logic [CTRL_W-1:0]       mem_ctrl,
  output logic [1:0]              occupancy,
  output logic [CNT_W-1:0]        stall_cycles
);

  localparam int ENTRY_W = entry_width(REG_LEN, REG_ADDR_LEN, CTRL_W);

  occ_e               state_reg;
  occ_e               state_next;
  logic [ENTRY_W-1:0] main_reg;
  logic [ENTRY_W-1:0] skid_reg;
  logic [ENTRY_W-1:0] ex_entry;
  logic               push;
  logic               pop;
  logic               load_main_ex;
  logic               load_main_skid;
  logic               load_skid;
  logic               stall_inc;

  assign ex_entry = {ex_rd_data, ex_rd_addr, ex_rd_enable, ex_ctrl};
  assign push     = ex_valid & ex_ready;
  assign pop      = mem_valid & mem_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= OCC_EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and datapath load selection; flush wins over push/pop
  always_comb begin
    state_next     = state_reg;
    load_main_ex   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_next = OCC_EMPTY;
    end else begin
      case (state_reg)
        OCC_EMPTY: begin
          if (push) begin
            state_next   = OCC_ONE;
            load_main_ex = 1'b1;
          end
        end
        OCC_ONE: begin
          if (push && pop) begin
            load_main_ex = 1'b1;
          end else if (push) begin
            state_next = OCC_FULL;
            load_skid  = 1'b1;
          end else if (pop) begin
            state_next = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          // ex_ready is low here, so only a pop can move the state
          if (pop) begin
            state_next     = OCC_ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_next = OCC_EMPTY;
      endcase
    end
  end

  // Output decode from registered state only; no mem_ready -> ex_ready path
  always_comb begin
    ex_ready  = (state_reg != OCC_FULL) & ~rst;
    mem_valid = (state_reg != OCC_EMPTY);
    occupancy = state_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_reg <= '0;
      skid_reg <= '0;
    end else begin
      if (load_main_ex) begin
        main_reg <= ex_entry;
      end else if (load_main_skid) begin
        main_reg <= skid_reg;
      end
      if (load_skid) begin
        skid_reg <= ex_entry;
      end
    end
  end

  assign mem_rd_data   = main_reg[ENTRY_W-1 -: REG_LEN];
  assign mem_rd_addr   = main_reg[CTRL_W+1 +: REG_ADDR_LEN];
  assign mem_rd_enable = main_reg[CTRL_W] & mem_valid;
  assign mem_ctrl      = main_reg[CTRL_W-1:0];

  // A flushed cycle is not counted as back-pressure
  assign stall_inc = mem_valid & ~mem_ready & ~flush;

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_stall_counter (
    .clk  (clk),
    .rst  (rst),
    .inc  (stall_inc),
    .count(stall_cycles)
  );

endmodule

// File: doc/ex_mem_skid.md
Name: ex_mem_skid

Overview:
Parametrised EX→MEM pipeline stage that replaces the plain always-enabled stage register with a valid/ready handshake.
- Two-entry skid buffer (main + skid) absorbs one cycle of MEM back-pressure without a combinational ready path from MEM to EX.
- Adds a synchronous flush for branch/exception squash and a saturating back-pressure cycle counter for performance analysis.
- Sits between the EX stage outputs and the MEM stage inputs.

Parameters:
REG_LEN, 32, width of rd data (matches `RegLen)
REG_ADDR_LEN, 5, width of rd address (matches `RegAddrLen)
CTRL_W, 4, width of opaque memory-op control field carried alongside
CNT_W, 16, width of stall cycle counter

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous active-high reset
flush  in  1  squash all held entries
ex_valid  in  1  EX offers an entry
ex_ready  out  1  stage can accept an entry this cycle
ex_rd_data  in  REG_LEN  write-back data
ex_rd_addr  in  REG_ADDR_LEN  write-back register address
ex_rd_enable  in  1  write-back enable
ex_ctrl  in  CTRL_W  memory-op control
mem_valid  out  1  head entry valid
mem_ready  in  1  MEM consumes head this cycle
mem_rd_data  out  REG_LEN  head data
mem_rd_addr  out  REG_ADDR_LEN  head address
mem_rd_enable  out  1  head write enable, gated by mem_valid
mem_ctrl  out  CTRL_W  head control
occupancy  out  2  entries held: 0, 1 or 2
stall_cycles  out  CNT_W  cycles with mem_valid=1 and mem_ready=0

Behaviour:
Reset and handshake
- Clock is clk. Reset is rst, synchronous and active-high: sampled only on posedge clk.
- While rst=1, ex_ready is forced to 0.
- At the first edge with rst=1, all outputs go to 0: mem_valid=0, mem_rd_data=0, mem_rd_addr=0, mem_rd_enable=0, mem_ctrl=0, occupancy=0, stall_cycles=0. Both entry registers are also cleared to 0.
- push = ex_valid & ex_ready; pop = mem_valid & mem_ready.
- ex_ready = (occupancy != 2) & !rst. It is a function of registered state only and has no path from mem_ready.
- mem_valid = (occupancy != 0). mem_* fields come directly from the main entry register.
- mem_rd_enable = main.rd_enable & mem_valid.
- Latency: an entry accepted in cycle N appears on mem_* in cycle N+1 when the stage was empty (or held one entry that popped).

State machine (EMPTY/ONE/FULL = occupancy 0/1/2)
- EMPTY: push → ONE, main<=ex fields.
- ONE: push&pop → ONE, main<=ex fields.
- ONE: push only → FULL, skid<=ex fields.
- ONE: pop only → EMPTY.
- ONE: neither → hold.
- FULL: pop → ONE, main<=skid.
- FULL: no pop → hold. Push is impossible because ex_ready=0.
- Ordering is strict FIFO; no entry is duplicated or dropped.

Flush and priority
- flush=1 forces next state EMPTY regardless of push/pop in the same cycle. A concurrent push is discarded.
- Entry data registers may retain stale values after flush; mem_rd_enable is 0 because mem_valid=0.
- Priority: rst > flush > push/pop.

Counter
- stall_cycles increments by 1 on each edge where mem_valid=1, mem_ready=0, rst=0 and flush=0.
- Saturates at 2^CNT_W−1; no wrap.
- Cleared only by rst.

Decomposition:
- Shared config header holds `RegLen, `RegAddrLen, `ResetEnable, plus new constants `OccEmpty=2'd0, `OccOne=2'd1, `OccFull=2'd2.
- One sub-module: sat_counter (params WIDTH; ports clk, rst, inc, count), instantiated for stall_cycles.
- Entry storage stays inline as two packed registers of width REG_LEN+REG_ADDR_LEN+1+CTRL_W.

Test Plan:
1. Reset: hold rst=1 two cycles with ex_valid=1 → ex_ready=0 throughout; after release all mem_* =0, occupancy=0, stall_cycles=0, ex_ready=1.
2. Streaming: mem_ready=1, push data 0x11,0x22,0x33 on consecutive cycles → mem_rd_data 0x11,0x22,0x33 on the following cycles; occupancy stays 1; stall_cycles=0.
3. Back-pressure: push 0xA (addr 3), then 0xB (addr 4) with mem_ready=0 → occupancy=2, ex_ready=0, mem_rd_data=0xA. Raise mem_ready → 0xA then 0xB emitted in order; occupancy 2→1→0.
4. Flush while FULL, with ex_valid=1 and data 0xC in the same cycle → next cycle occupancy=0, mem_valid=0, mem_rd_enable=0; 0xC never appears.
5. Counter saturation with CNT_W=4: hold mem_valid=1, mem_ready=0 for 20 cycles → stall_cycles reaches 15 and stays 15.
6. Reset mid-operation while FULL: assert rst one cycle → occupancy=0, stall_cycles=0, mem_rd_data=0; the next push of 0x5 emerges alone.
